// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small FIFO and drain in free slots, with WAW squash and starvation stall.
module wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  pipe_wd_i,
  input  logic        pipe_wreg_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_wd_i,
  input  logic [31:0] mdu_wdata_i,
  output logic        mdu_ready_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0]    LP_MAX_WAIT = 4'(MAX_WAIT);
  localparam logic [CW-1:0] LP_DEPTH    = CW'(DEPTH);

  logic [4:0]       r_fifo_wd   [DEPTH];
  logic [31:0]      r_fifo_data [DEPTH];
  logic [DEPTH-1:0] r_fifo_live;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_age;
  logic [4:0]       r_wd;
  logic             r_wreg;
  logic [31:0]      r_wdata;

  logic w_pipe_eff;
  logic w_empty;
  logic w_head_live;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_push_live;

  assign w_pipe_eff  = pipe_wreg_i && (pipe_wd_i != 5'd0);
  assign w_empty     = (r_count == '0);
  assign w_head_live = !w_empty && r_fifo_live[r_rd_ptr];
  assign w_ready     = (r_count < LP_DEPTH);
  assign w_push      = mdu_valid_i && w_ready && (mdu_wd_i != 5'd0);
  // A dead head is dropped even while the pipe owns the port; a live one waits.
  assign w_pop       = !w_empty && (!w_head_live || !w_pipe_eff);
  assign w_push_live = !(w_pipe_eff && (pipe_wd_i == mdu_wd_i));

  assign mdu_ready_o = !rst && w_ready;
  assign stallreq_o  = (r_age == LP_MAX_WAIT);
  assign wd_o        = r_wd;
  assign wreg_o      = r_wreg;
  assign wdata_o     = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_live <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_age       <= '0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
    end else begin
      if (w_pipe_eff) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_fifo_wd[i] == pipe_wd_i) r_fifo_live[i] <= 1'b0;
        end
      end

      // The write slot never holds a valid entry, so this overrides any squash hit there.
      if (w_push) begin
        r_fifo_wd[r_wr_ptr]   <= mdu_wd_i;
        r_fifo_data[r_wr_ptr] <= mdu_wdata_i;
        r_fifo_live[r_wr_ptr] <= w_push_live;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end

      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);

      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_pop || w_empty) begin
        r_age <= '0;
      end else if (w_head_live && w_pipe_eff && (r_age != LP_MAX_WAIT)) begin
        r_age <= r_age + 4'd1;
      end

      if (w_pipe_eff) begin
        r_wd    <= pipe_wd_i;
        r_wreg  <= 1'b1;
        r_wdata <= pipe_wdata_i;
      end else if (w_head_live) begin
        r_wd    <= r_fifo_wd[r_rd_ptr];
        r_wreg  <= 1'b1;
        r_wdata <= r_fifo_data[r_rd_ptr];
      end else begin
        r_wd    <= '0;
        r_wreg  <= 1'b0;
        r_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  pipe_wd_i;
  logic        pipe_wreg_i;
  logic [31:0] pipe_wdata_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_wd_i;
  logic [31:0] mdu_wdata_i;
  logic        mdu_ready_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wd_i(pipe_wd_i), .pipe_wreg_i(pipe_wreg_i), .pipe_wdata_i(pipe_wdata_i),
    .mdu_valid_i(mdu_valid_i), .mdu_wd_i(mdu_wd_i), .mdu_wdata_i(mdu_wdata_i),
    .mdu_ready_o(mdu_ready_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          m_age;
  bit          m_init;
  logic [4:0]  e_wd;
  logic        e_wreg;
  logic [31:0] e_data;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic r, input logic pw, input logic [4:0] pwd, input logic [31:0] pdata,
                      input logic mv, input logic [4:0] mwd, input logic [31:0] mdata);
    bit   pe, rdy, empty, hlive, pop;
    ent_t e;
    rst = r; pipe_wreg_i = pw; pipe_wd_i = pwd; pipe_wdata_i = pdata;
    mdu_valid_i = mv; mdu_wd_i = mwd; mdu_wdata_i = mdata;
    #1;
    rdy = !r && (q.size() < DEPTH);
    if (m_init || r) chk("ready", mdu_ready_o, rdy);
    if (m_init) chk("stall", stallreq_o, m_age == MAX_WAIT);
    if (r) begin
      q.delete(); m_age = 0; m_init = 1;
      e_wd = '0; e_wreg = 1'b0; e_data = '0;
    end else begin
      pe    = pw && (pwd != 0);
      empty = (q.size() == 0);
      hlive = !empty && q[0].live;
      pop   = !empty && (!hlive || !pe);
      if (pe) begin
        e_wd = pwd; e_wreg = 1'b1; e_data = pdata;
      end else if (hlive) begin
        e_wd = q[0].wd; e_wreg = 1'b1; e_data = q[0].d;
      end else begin
        e_wd = '0; e_wreg = 1'b0; e_data = '0;
      end
      if (pop || empty) m_age = 0;
      else if (hlive && pe && m_age < MAX_WAIT) m_age++;
      if (pop) void'(q.pop_front());
      if (pe) foreach (q[i]) if (q[i].wd == pwd) q[i].live = 0;
      if (mv && rdy && mwd != 0) begin
        e.wd = mwd; e.d = mdata; e.live = !(pe && pwd == mwd);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (m_init) begin
      chk("wd", wd_o, e_wd);
      chk("wreg", wreg_o, e_wreg);
      chk("wdata", wdata_o, e_data);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic       rr, pw, mv;
    logic [4:0] pwd, mwd;
    total = 0; bad = 0; m_init = 0; m_age = 0;

    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_wreg", wreg_o, 1'b0);
    idle();
    chk("ready_after_rst", mdu_ready_o, 1'b1);

    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("x5_wd", wd_o, 5'd5);
    chk("x5_data", wdata_o, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    chk("x0_wreg", wreg_o, 1'b0);

    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
    chk("x7_not_yet", wreg_o, 1'b0);
    chk("x7_ready", mdu_ready_o, 1'b1);
    idle();
    chk("x7_wd", wd_o, 5'd7);
    chk("x7_data", wdata_o, 32'h12345678);

    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h88);
    step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    chk("full_ready", mdu_ready_o, 1'b0);
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    chk("stall_early", stallreq_o, 1'b0);
    step(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    chk("stall_rise", stallreq_o, 1'b1);
    idle();
    chk("x8_out", wd_o, 5'd8);
    chk("stall_drop", stallreq_o, 1'b0);
    idle();
    chk("x9_out", wd_o, 5'd9);

    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1);
    step(1'b0, 1'b1, 5'd10, 32'h2, 1'b0, 5'd0, 32'd0);
    chk("waw_data", wdata_o, 32'h2);
    idle();
    chk("waw_silent", wreg_o, 1'b0);
    idle();

    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hB);
    step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hC);
    chk("full2_ready", mdu_ready_o, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD);
    chk("after_pop_ready", mdu_ready_o, 1'b1);
    idle();
    chk("x12_out", wd_o, 5'd12);
    idle();
    chk("x13_refused", wreg_o, 1'b0);

    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd14, 32'hE);
    step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd15, 32'hF);
    step(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    chk("midrst_wreg", wreg_o, 1'b0);
    chk("midrst_data", wdata_o, 32'd0);
    idle();
    chk("post_rst_wreg", wreg_o, 1'b0);
    chk("post_rst_ready", mdu_ready_o, 1'b1);

    for (int n = 0; n < 500; n++) begin
      rr  = ($urandom % 64) == 0;
      pw  = $urandom % 2;
      if (stallreq_o && ($urandom % 4) != 0) pw = 1'b0;
      pwd = 5'($urandom % 8);
      mv  = $urandom % 2;
      mwd = 5'($urandom % 8);
      step(rr, pw, pwd, $urandom, mv, mwd, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
